// File: rtl/wish_stream_pkg.sv
// Shared definitions for the wish_pack / wish_unpack width-conversion pair.
// Both blocks use the same slice-ordering rule, so pack followed by unpack is the identity.
package wish_stream_pkg;

    localparam bit ENDIAN_LITTLE = 1'b1;
    localparam bit ENDIAN_BIG    = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Bit offset of narrow word idx inside the wide word
    function automatic int slice_offset(input int idx, input int num, input int width,
                                        input bit endian);
        return endian ? idx * width : (num - 1 - idx) * width;
    endfunction

endpackage

// File: rtl/wish_out_reg.sv
// Wide-word holding register with valid flag.
// A new word may load in the same cycle the current one drains.
module wish_out_reg #(
    parameter int DW = 32,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] ld_dat,
    input  logic [TW-1:0] ld_tgc,
    input  logic          ack,
    output logic          vld,
    output logic [DW-1:0] dat,
    output logic [TW-1:0] tgc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
            tgc <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= ld_dat;
            tgc <= ld_tgc;
        end else if (vld && ack) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/wish_pack.sv
// Packs NUM_PACK narrow stream words into one wide word; tags of the
// constituent words are ORed together.
module wish_pack
    import wish_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter bit LITTLE_ENDIAN = ENDIAN_LITTLE
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    input  logic [DATA_WIDTH-1:0]          s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    input  logic                           d_ack_i,
    output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o
);

    localparam int IDX_W = clog2(NUM_PACK);
    localparam int WW    = DATA_WIDTH * NUM_PACK;

    logic [IDX_W-1:0]     idx;
    logic [WW-1:0]        acc;
    logic [TGC_WIDTH-1:0] tag_acc;
    logic [WW-1:0]        word_p0;
    logic [TGC_WIDTH-1:0] tag_p0;
    logic                 last;
    logic                 out_v;
    logic                 load;

    assign last      = (idx == IDX_W'(NUM_PACK - 1));
    assign s_ack_o   = s_stb_i & s_cyc_i & (~last | ~out_v | d_ack_i);
    assign s_stall_o = s_stb_i & s_cyc_i & ~s_ack_o;
    assign load      = s_ack_o & last;
    assign d_stb_o   = out_v;
    assign d_cyc_o   = out_v | (idx != '0);

    // Accumulator with the incoming word merged into its slot
    always_comb begin
        word_p0 = acc;
        for (int k = 0; k < NUM_PACK; k++) begin
            if (idx == IDX_W'(k))
                word_p0[slice_offset(k, NUM_PACK, DATA_WIDTH, LITTLE_ENDIAN) +: DATA_WIDTH] = s_dat_i;
        end
        tag_p0 = tag_acc | s_tgc_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx     <= '0;
            acc     <= '0;
            tag_acc <= '0;
        end else if (!s_cyc_i) begin
            // Source dropped the cycle: discard any partial word
            idx     <= '0;
            tag_acc <= '0;
        end else if (s_ack_o) begin
            acc     <= word_p0;
            tag_acc <= last ? '0 : tag_p0;
            idx     <= last ? '0 : idx + IDX_W'(1);
        end
    end

    // Completed word hands off to the output register
    wish_out_reg #(
        .DW (WW),
        .TW (TGC_WIDTH)
    ) u_out_reg (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .load   (load),
        .ld_dat (word_p0),
        .ld_tgc (tag_p0),
        .ack    (d_ack_i),
        .vld    (out_v),
        .dat    (d_dat_o),
        .tgc    (d_tgc_o)
    );

endmodule

// File: tb/tb_wish_pack.sv
// Directed bench for wish_pack: a little-endian and a big-endian instance share
// the same source stimulus and destination acknowledge.
module tb_wish_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_stb, s_cyc, d_ack;
    logic [7:0]  s_dat;
    logic [1:0]  s_tgc;

    logic        le_ack, le_stall, le_stb, le_cyc;
    logic [31:0] le_dat;
    logic [1:0]  le_tgc;
    logic        be_ack, be_stall, be_stb, be_cyc;
    logic [31:0] be_dat;
    logic [1:0]  be_tgc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b1)) dut_le (
        .clk_i(clk), .rst_n_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc),
        .s_ack_o(le_ack), .s_stall_o(le_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
        .d_stb_o(le_stb), .d_cyc_o(le_cyc), .d_ack_i(d_ack), .d_dat_o(le_dat), .d_tgc_o(le_tgc)
    );

    wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b0)) dut_be (
        .clk_i(clk), .rst_n_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc),
        .s_ack_o(be_ack), .s_stall_o(be_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
        .d_stb_o(be_stb), .d_cyc_o(be_cyc), .d_ack_i(d_ack), .d_dat_o(be_dat), .d_tgc_o(be_tgc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one narrow word that must be accepted without stall, then clock it in
    task automatic send(input logic [7:0] d, input logic [1:0] t, input string tag);
        s_stb = 1'b1;
        s_cyc = 1'b1;
        s_dat = d;
        s_tgc = t;
        #1;
        chk({tag, "_le_ack"}, le_ack, 1'b1);
        chk({tag, "_be_ack"}, be_ack, 1'b1);
        chk({tag, "_stall"}, {le_stall, be_stall}, 2'b00);
        tick();
    endtask

    task automatic idle();
        s_stb = 1'b0;
        s_cyc = 1'b0;
        s_dat = 8'h00;
        s_tgc = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d_ack = 1'b0;
        idle();
        #3;
        chk("rst_le_out", {le_ack, le_stall, le_stb, le_cyc, le_tgc, le_dat}, 38'h0);
        chk("rst_be_out", {be_ack, be_stall, be_stb, be_cyc, be_tgc, be_dat}, 38'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic packing, both orderings, tag OR
        d_ack = 1'b1;
        send(8'h11, 2'b01, "w0");
        send(8'h22, 2'b00, "w1");
        send(8'h33, 2'b10, "w2");
        send(8'h44, 2'b00, "w3");
        idle();
        #1;
        chk("basic_stb", {le_stb, be_stb}, 2'b11);
        chk("basic_le_dat", le_dat, 32'h44332211);
        chk("basic_be_dat", be_dat, 32'h11223344);
        chk("basic_tgc", {le_tgc, be_tgc}, 4'b1111);
        tick();
        chk("basic_stb_one_cycle", {le_stb, be_stb}, 2'b00);
        chk("basic_cyc_idle", {le_cyc, be_cyc}, 2'b00);

        // Tag accumulator cleared between words
        send(8'h55, 2'b00, "t0");
        send(8'h66, 2'b00, "t1");
        send(8'h77, 2'b00, "t2");
        send(8'h88, 2'b00, "t3");
        idle();
        #1;
        chk("tag_clear_tgc", {le_tgc, be_tgc}, 4'b0000);
        chk("tag_clear_le_dat", le_dat, 32'h88776655);
        tick();

        // Backpressure: hold one word, final word of the next must stall
        d_ack = 1'b0;
        send(8'hA1, 2'b00, "a0");
        send(8'hA2, 2'b00, "a1");
        send(8'hA3, 2'b00, "a2");
        send(8'hA4, 2'b00, "a3");
        send(8'hB1, 2'b00, "b0");
        send(8'hB2, 2'b00, "b1");
        send(8'hB3, 2'b00, "b2");
        s_dat = 8'hB4;
        #1;
        chk("bp_ack_low", {le_ack, be_ack}, 2'b00);
        chk("bp_stall_high", {le_stall, be_stall}, 2'b11);
        chk("bp_held_le", le_dat, 32'hA4A3A2A1);
        tick();
        chk("bp_still_stall", {le_stall, be_stall, le_stb}, 3'b111);
        chk("bp_held_be", be_dat, 32'hA1A2A3A4);
        d_ack = 1'b1;
        #1;
        chk("bp_release_ack", {le_ack, be_ack, le_stall}, 3'b110);
        tick();
        idle();
        d_ack = 1'b0;
        #1;
        chk("bp_new_stb", {le_stb, be_stb}, 2'b11);
        chk("bp_new_le", le_dat, 32'hB4B3B2B1);
        chk("bp_new_be", be_dat, 32'hB1B2B3B4);
        tick();
        chk("bp_new_held", le_dat, 32'hB4B3B2B1);
        d_ack = 1'b1;
        tick();
        chk("bp_drained", {le_stb, be_stb}, 2'b00);

        // Source abort mid-word
        send(8'hAA, 2'b11, "ab0");
        send(8'hBB, 2'b11, "ab1");
        s_stb = 1'b0;
        #1;
        chk("abort_cyc_partial", {le_cyc, be_cyc}, 2'b11);
        s_cyc = 1'b0;
        tick();
        chk("abort_cyc_low", {le_cyc, be_cyc}, 2'b00);
        send(8'h01, 2'b00, "c0");
        send(8'h02, 2'b00, "c1");
        send(8'h03, 2'b00, "c2");
        send(8'h04, 2'b00, "c3");
        idle();
        #1;
        chk("abort_le_dat", le_dat, 32'h04030201);
        chk("abort_be_dat", be_dat, 32'h01020304);
        chk("abort_tgc", {le_tgc, be_tgc}, 4'b0000);
        tick();

        // Asynchronous reset with held word and partial word
        d_ack = 1'b0;
        send(8'hC1, 2'b00, "r0");
        send(8'hC2, 2'b00, "r1");
        send(8'hC3, 2'b00, "r2");
        send(8'hC4, 2'b00, "r3");
        send(8'hD1, 2'b01, "r4");
        send(8'hD2, 2'b01, "r5");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_le", {le_stb, le_cyc, le_tgc, le_dat}, 36'h0);
        chk("areset_be", {be_stb, be_cyc, be_tgc, be_dat}, 36'h0);
        tick();
        rst_n = 1'b1;
        d_ack = 1'b1;
        tick();
        send(8'hE1, 2'b00, "e0");
        send(8'hE2, 2'b00, "e1");
        send(8'hE3, 2'b00, "e2");
        #1;
        chk("post_rst_no_early", {le_stb, be_stb}, 2'b00);
        send(8'hE4, 2'b00, "e3");
        idle();
        #1;
        chk("post_rst_le", {le_stb, le_tgc, le_dat}, {1'b1, 2'b00, 32'hE4E3E2E1});
        chk("post_rst_be", {be_stb, be_tgc, be_dat}, {1'b1, 2'b00, 32'hE1E2E3E4});
        tick();
        chk("post_rst_single", {le_stb, be_stb}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
